// File: rtl/bf_core_pipelined_io.sv
// Tape-machine core with 3-bit opcodes, a hardware loop stack, a forward-skip scanner
// and valid/ready byte streams. ROM and RAM are synchronous with one cycle of read latency.
module bf_core_pipelined_io #(
  parameter int DATA_WIDTH = 8,
  parameter int TAPE_AW    = 16,
  parameter int PC_WIDTH   = 16,
  parameter int LOOP_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   prog_len,
  output logic [PC_WIDTH-1:0]   pmem_addr,
  input  logic [2:0]            pmem_data_read,
  output logic [TAPE_AW-1:0]    tape_addr,
  input  logic [DATA_WIDTH-1:0] tape_data_read,
  output logic                  tape_we,
  output logic [DATA_WIDTH-1:0] tape_data_write,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  halted,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int SPW = $clog2(LOOP_DEPTH) + 1;

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_DEC   = 3'd1;
  localparam logic [2:0] OP_INCSP = 3'd2;
  localparam logic [2:0] OP_DECSP = 3'd3;
  localparam logic [2:0] OP_OPEN  = 3'd4;
  localparam logic [2:0] OP_CLOSE = 3'd5;
  localparam logic [2:0] OP_CIN   = 3'd6;
  localparam logic [2:0] OP_COUT  = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_EXEC, S_SKIP_F, S_SKIP_C, S_IN_WAIT, S_OUT_WAIT, S_HALT, S_ERROR
  } state_t;

  state_t                state;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   depth;
  logic [PC_WIDTH-1:0]   depth_next;
  logic [TAPE_AW-1:0]    sp;
  logic [SPW-1:0]        stk_ptr;
  logic [SPW-2:0]        top_idx;
  logic [PC_WIDTH-1:0]   stack [LOOP_DEPTH];
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [1:0]            err_q;
  logic                  cell_zero;
  logic                  stk_full;
  logic                  stk_empty;
  logic                  push;

  assign pmem_addr = pc;
  assign tape_addr = sp;
  assign out_data  = out_data_q;
  assign err_code  = err_q;
  assign in_ready  = (state == S_IN_WAIT);
  assign out_valid = (state == S_OUT_WAIT);
  assign halted    = (state == S_HALT);
  assign error     = (state == S_ERROR);

  assign cell_zero = (tape_data_read == '0);
  assign stk_full  = (stk_ptr == SPW'(LOOP_DEPTH));
  assign stk_empty = (stk_ptr == '0);
  assign top_idx   = stk_ptr[SPW-2:0] - 1'b1;
  assign push      = (state == S_EXEC) && (pmem_data_read == OP_OPEN) && !cell_zero && !stk_full;

  always_comb begin
    tape_we         = 1'b0;
    tape_data_write = tape_data_read;
    if (state == S_EXEC && pmem_data_read == OP_INC) begin
      tape_we         = 1'b1;
      tape_data_write = tape_data_read + 1'b1;
    end else if (state == S_EXEC && pmem_data_read == OP_DEC) begin
      tape_we         = 1'b1;
      tape_data_write = tape_data_read - 1'b1;
    end else if (state == S_IN_WAIT && in_valid) begin
      tape_we         = 1'b1;
      tape_data_write = in_data;
    end
  end

  // Skip scanner counts bracket nesting only; the loop stack is left alone while skipping.
  always_comb begin
    depth_next = depth;
    if (pmem_data_read == OP_OPEN)       depth_next = depth + 1'b1;
    else if (pmem_data_read == OP_CLOSE) depth_next = depth - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push) stack[stk_ptr[SPW-2:0]] <= pc + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      sp         <= '0;
      stk_ptr    <= '0;
      depth      <= '0;
      out_data_q <= '0;
      err_q      <= 2'd0;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_FETCH;
        S_FETCH: state <= (pc == prog_len) ? S_HALT : S_EXEC;
        S_EXEC: begin
          state <= S_FETCH;
          case (pmem_data_read)
            OP_INC, OP_DEC: pc <= pc + 1'b1;
            OP_INCSP: begin
              sp <= sp + 1'b1;
              pc <= pc + 1'b1;
            end
            OP_DECSP: begin
              sp <= sp - 1'b1;
              pc <= pc + 1'b1;
            end
            OP_OPEN: begin
              if (cell_zero) begin
                depth <= PC_WIDTH'(1);
                pc    <= pc + 1'b1;
                state <= S_SKIP_F;
              end else if (stk_full) begin
                err_q <= 2'd1;
                state <= S_ERROR;
              end else begin
                stk_ptr <= stk_ptr + 1'b1;
                pc      <= pc + 1'b1;
              end
            end
            OP_CLOSE: begin
              if (stk_empty) begin
                err_q <= 2'd2;
                state <= S_ERROR;
              end else if (!cell_zero) begin
                pc <= stack[top_idx];
              end else begin
                stk_ptr <= stk_ptr - 1'b1;
                pc      <= pc + 1'b1;
              end
            end
            OP_CIN: state <= S_IN_WAIT;
            OP_COUT: begin
              out_data_q <= tape_data_read;
              state      <= S_OUT_WAIT;
            end
            default: state <= S_FETCH;
          endcase
        end
        S_SKIP_F: begin
          if (pc == prog_len) begin
            err_q <= 2'd3;
            state <= S_ERROR;
          end else begin
            state <= S_SKIP_C;
          end
        end
        S_SKIP_C: begin
          depth <= depth_next;
          pc    <= pc + 1'b1;
          state <= (depth_next == '0) ? S_FETCH : S_SKIP_F;
        end
        S_IN_WAIT: begin
          if (in_valid) begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_HALT:  state <= S_HALT;
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_core_pipelined_io.sv
// Directed bench for bf_core_pipelined_io: behavioural ROM/RAM models, a table of whole
// programs with hand-computed end states, and hand-written handshake/reset sequences.
module tb_bf_core_pipelined_io;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] prog_len = '0;
  logic [15:0] pmem_addr;
  logic [2:0]  pmem_data_read;
  logic [15:0] tape_addr;
  logic [7:0]  tape_data_read;
  logic        tape_we;
  logic [7:0]  tape_data_write;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        halted;
  logic        error;
  logic [1:0]  err_code;

  bf_core_pipelined_io #(
    .DATA_WIDTH(8), .TAPE_AW(16), .PC_WIDTH(16), .LOOP_DEPTH(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .prog_len(prog_len),
    .pmem_addr(pmem_addr), .pmem_data_read(pmem_data_read),
    .tape_addr(tape_addr), .tape_data_read(tape_data_read),
    .tape_we(tape_we), .tape_data_write(tape_data_write),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .halted(halted), .error(error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  logic [2:0] prog_mem [0:63];
  logic [7:0] tape_mem [0:65535];
  logic       tape_clr = 1'b0;

  always @(posedge clock) begin
    pmem_data_read <= prog_mem[pmem_addr[5:0]];
    tape_data_read <= tape_mem[tape_addr];
    if (tape_clr) begin
      for (int i = 0; i < 65536; i++) tape_mem[i] <= 8'h00;
    end else if (tape_we) begin
      tape_mem[tape_addr] <= tape_data_write;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic load_prog(input string p);
    for (int i = 0; i < 64; i++) prog_mem[i] = 3'd0;
    for (int i = 0; i < p.len(); i++) begin
      case (p[i])
        "+": prog_mem[i] = 3'd0;
        "-": prog_mem[i] = 3'd1;
        ">": prog_mem[i] = 3'd2;
        "<": prog_mem[i] = 3'd3;
        "[": prog_mem[i] = 3'd4;
        "]": prog_mem[i] = 3'd5;
        ",": prog_mem[i] = 3'd6;
        default: prog_mem[i] = 3'd7;
      endcase
    end
    prog_len = 16'(p.len());
  endtask

  task automatic do_reset();
    start    = 1'b0;
    reset_n  = 1'b0;
    tape_clr = 1'b1;
    @(posedge clock); #1;
    tape_clr = 1'b0;
    reset_n  = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  typedef struct {
    string      prog;
    logic [7:0] in_byte;
    logic       exp_halt;
    logic       exp_err;
    logic [1:0] exp_code;
    logic [15:0] exp_pc;
    logic [15:0] exp_sp;
    logic [7:0] exp_cell0;
    int         exp_nout;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int nout;
    int cyc;
    logic [7:0] last_out;

    vecs[0] = '{"+++.",       8'h00, 1'b1, 1'b0, 2'd0, 16'd4,  16'h0000, 8'h03, 1, 8'h03};
    vecs[1] = '{"-<",         8'h00, 1'b1, 1'b0, 2'd0, 16'd2,  16'hFFFF, 8'hFF, 0, 8'h00};
    vecs[2] = '{"++[->+<]>.", 8'h00, 1'b1, 1'b0, 2'd0, 16'd10, 16'h0001, 8'h00, 1, 8'h02};
    vecs[3] = '{"[[]+].",     8'h00, 1'b1, 1'b0, 2'd0, 16'd6,  16'h0000, 8'h00, 1, 8'h00};
    vecs[4] = '{"[+",         8'h00, 1'b0, 1'b1, 2'd3, 16'd2,  16'h0000, 8'h00, 0, 8'h00};
    vecs[5] = '{"+[[[",       8'h00, 1'b0, 1'b1, 2'd1, 16'd3,  16'h0000, 8'h01, 0, 8'h00};
    vecs[6] = '{"]",          8'h00, 1'b0, 1'b1, 2'd2, 16'd0,  16'h0000, 8'h00, 0, 8'h00};
    vecs[7] = '{",.",         8'h5A, 1'b1, 1'b0, 2'd0, 16'd2,  16'h0000, 8'h5A, 1, 8'h5A};
    vecs[8] = '{"+[-].",      8'h00, 1'b1, 1'b0, 2'd0, 16'd5,  16'h0000, 8'h00, 1, 8'h00};

    load_prog("");
    do_reset();
    check("reset pc", pmem_addr, 16'd0);
    check("reset sp", tape_addr, 16'd0);
    check("reset halted", halted, 1'b0);
    check("reset error", error, 1'b0);
    check("reset err_code", err_code, 2'd0);
    check("reset in_ready", in_ready, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset tape_we", tape_we, 1'b0);

    // Empty program ends on the first FETCH.
    pulse_start();
    @(posedge clock); #1;
    check("empty halted", halted, 1'b1);
    check("empty pc", pmem_addr, 16'd0);

    for (int v = 0; v < 9; v++) begin
      load_prog(vecs[v].prog);
      do_reset();
      in_valid  = 1'b1;
      in_data   = vecs[v].in_byte;
      out_ready = 1'b1;
      pulse_start();
      nout = 0;
      last_out = 8'h00;
      cyc = 0;
      while (!(halted || error) && cyc < 2000) begin
        if (out_valid && out_ready) begin
          nout++;
          last_out = out_data;
        end
        @(posedge clock); #1;
        cyc++;
      end
      check({vecs[v].prog, " done"}, halted | error, 1'b1);
      check({vecs[v].prog, " halted"}, halted, vecs[v].exp_halt);
      check({vecs[v].prog, " error"}, error, vecs[v].exp_err);
      check({vecs[v].prog, " err_code"}, err_code, vecs[v].exp_code);
      check({vecs[v].prog, " pc"}, pmem_addr, vecs[v].exp_pc);
      check({vecs[v].prog, " sp"}, tape_addr, vecs[v].exp_sp);
      check({vecs[v].prog, " cell0"}, tape_mem[0], vecs[v].exp_cell0);
      check({vecs[v].prog, " nout"}, nout, vecs[v].exp_nout);
      if (vecs[v].exp_nout > 0) check({vecs[v].prog, " out_data"}, last_out, vecs[v].exp_out);
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end

    // "+++." timing: 3 x 2 cycles, COUT 2 cycles + 1 OUT_WAIT cycle, then the end FETCH:
    // halted becomes visible 10 edges after the edge that samples start.
    load_prog("+++.");
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    cyc = 0;
    while (!halted && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("+++. halt latency", cyc, 10);
    check("+++. out_data", out_data, 8'h03);
    out_ready = 1'b0;

    // ",." with a slow producer and a stalled consumer.
    load_prog(",.");
    do_reset();
    pulse_start();
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("cin in_ready", in_ready, 1'b1);
    repeat (4) begin
      @(posedge clock); #1;
    end
    check("cin still waiting", in_ready, 1'b1);
    check("cin no write", tape_we, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #1;
    check("cin write strobe", tape_we, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      check("cout stalled valid", out_valid, 1'b1);
      check("cout stalled data", out_data, 8'h5A);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    cyc = 0;
    while (!halted && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    check(",. halted", halted, 1'b1);
    check(",. held out_data", out_data, 8'h5A);
    check(",. cell0", tape_mem[0], 8'h5A);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of OUT_WAIT.
    load_prog(",.");
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h33;
    pulse_start();
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("pre-reset out_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset pc", pmem_addr, 16'd0);
    check("async reset tape_we", tape_we, 1'b0);
    check("async reset halted", halted, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("idle after reset", in_ready | out_valid | halted | error, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
